etapa_operandos: RTL

ETAPA_OPERANDOS -- requirements
Module: etapa_operandos

---
 rtl/etapa_operandos.sv | 86 ++++++++
 1 files changed

// File: rtl/etapa_operandos.sv
// Operand-fetch stage: register file, write-back port, flag register and a
// one-deep valid/ready output register toward the ALU. Optional macro: ETAPA_OPERANDOS_BYPASS_EN.
module etapa_operandos #(
    parameter int BITS = 8,
    parameter int FUNC = 4,
    parameter int DIRS = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inValido,
    output logic            inListo,
    input  logic [FUNC-1:0] funcion,
    input  logic [DIRS-1:0] dirA,
    input  logic [DIRS-1:0] dirB,
    input  logic [BITS-1:0] inmediato,
    input  logic            usaInmediato,
    output logic            outValido,
    input  logic            outListo,
    output logic [FUNC-1:0] funcionALU,
    output logic [BITS-1:0] vectorA,
    output logic [BITS-1:0] vectorB,
    input  logic            wbValido,
    input  logic [DIRS-1:0] wbDir,
    input  logic [BITS-1:0] wbDato,
    input  logic            wbZero,
    input  logic            wbOverflow,
    output logic [1:0]      banderas
);

    localparam int ENTRIES = 2 ** DIRS;

    logic [BITS-1:0] regs [ENTRIES];
    logic [BITS-1:0] dato_a;
    logic [BITS-1:0] dato_b;
    logic [BITS-1:0] oper_b;
    logic            carga;

    assign inListo = !outValido || outListo;
    assign carga   = inValido && inListo;

    always_comb begin
        dato_a = (dirA == '0) ? '0 : regs[dirA];
        dato_b = (dirB == '0) ? '0 : regs[dirB];
`ifdef ETAPA_OPERANDOS_BYPASS_EN
        // A write landing this same edge is forwarded so the operand is never stale.
        if (wbValido && (wbDir != '0) && (wbDir == dirA)) dato_a = wbDato;
        if (wbValido && (wbDir != '0) && (wbDir == dirB)) dato_b = wbDato;
`endif
        oper_b = usaInmediato ? inmediato : dato_b;
    end

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) regs[i] <= '0;
        end else if (wbValido && (wbDir != '0)) begin
            regs[wbDir] <= wbDato;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            banderas <= 2'b00;
        end else if (wbValido) begin
            banderas <= {wbOverflow, wbZero};
        end
    end

    // Operands only change on a load, so they hold while stalled or idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValido  <= 1'b0;
            funcionALU <= '0;
            vectorA    <= '0;
            vectorB    <= '0;
        end else if (carga) begin
            outValido  <= 1'b1;
            funcionALU <= funcion;
            vectorA    <= dato_a;
            vectorB    <= oper_b;
        end else if (outListo) begin
            outValido  <= 1'b0;
        end
    end

endmodule
